// File: rtl/ppcpu_forwarding_stall.sv
// Five-stage MIPS-subset pipeline (IF/ID/EXE/MEM/WB) with internal ROM, RAM and register file.
// Define PPCPU_FORWARD_EN for operand forwarding with a load-use-only stall; otherwise hazards stall until write-back.
`timescale 1ns/1ps

module ppcpu_forwarding_stall (
    input  logic        Clock,
    input  logic        Resetn,
    output logic [31:0] PC,
    output logic [31:0] IF_INST,
    output logic [31:0] ID_INST,
    output logic [31:0] EXE_ALU,
    output logic [31:0] MEM_ALU,
    output logic [31:0] WB_ALU,
    output logic        stall
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR,
        OP_ADDI,
        OP_ANDI,
        OP_ORI,
        OP_LW,
        OP_SW
    } op_e;

    function automatic op_e decode(input logic [5:0] opc, input logic [5:0] funct);
        op_e op;
        op = OP_NOP;
        case (opc)
            6'h00: begin
                case (funct)
                    6'h20:   op = OP_ADD;
                    6'h22:   op = OP_SUB;
                    6'h24:   op = OP_AND;
                    6'h25:   op = OP_OR;
                    default: op = OP_NOP;
                endcase
            end
            6'h08:   op = OP_ADDI;
            6'h0C:   op = OP_ANDI;
            6'h0D:   op = OP_ORI;
            6'h23:   op = OP_LW;
            6'h2B:   op = OP_SW;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    logic [31:0] regs [32];
    logic [31:0] ram  [32];

    // ID/EX register; an all-zero value is a bubble
    op_e         ex_op;
    logic [4:0]  ex_dst;
    logic        ex_wr;
    logic [31:0] ex_imm;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
`ifdef PPCPU_FORWARD_EN
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
`endif

    // EX/MEM register (ALU result is MEM_ALU)
    logic [31:0] mem_sdata;
    logic [4:0]  mem_dst;
    logic        mem_wr;
    logic        mem_load;
    logic        mem_store;

    // MEM/WB register (ALU result is WB_ALU)
    logic [31:0] wb_val;
    logic [4:0]  wb_dst;
    logic        wb_wr;

    always_comb begin
        case (PC[6:2])
            5'd0:    IF_INST = 32'h2001_0004;
            5'd1:    IF_INST = 32'h8C22_0000;
            5'd2:    IF_INST = 32'h0041_1820;
            5'd3:    IF_INST = 32'h0061_2022;
            5'd4:    IF_INST = 32'hAC04_0008;
            5'd5:    IF_INST = 32'h8C05_0008;
            5'd6:    IF_INST = 32'h00A3_3025;
            5'd7:    IF_INST = 32'h00C4_3824;
            default: IF_INST = '0;
        endcase
    end

    op_e         id_op;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_dst;
    logic        id_wr;
    logic        id_uses_rt;
    logic [31:0] id_imm;
    logic [31:0] id_a;
    logic [31:0] id_b;

    always_comb begin
        id_op      = decode(ID_INST[31:26], ID_INST[5:0]);
        id_rs      = ID_INST[25:21];
        id_rt      = ID_INST[20:16];
        id_dst     = '0;
        id_uses_rt = 1'b0;
        id_imm     = {{16{ID_INST[15]}}, ID_INST[15:0]};
        case (id_op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                id_dst     = ID_INST[15:11];
                id_uses_rt = 1'b1;
            end
            OP_ADDI, OP_LW: id_dst = id_rt;
            OP_ANDI, OP_ORI: begin
                id_dst = id_rt;
                id_imm = {16'h0000, ID_INST[15:0]};
            end
            OP_SW:   id_uses_rt = 1'b1;
            default: id_dst = '0;
        endcase
        id_wr = (id_dst != 5'd0);
        // Write-through: a register written back this cycle is read with its new value
        id_a = (id_rs == 5'd0) ? '0 : (wb_wr && wb_dst == id_rs) ? wb_val : regs[id_rs];
        id_b = (id_rt == 5'd0) ? '0 : (wb_wr && wb_dst == id_rt) ? wb_val : regs[id_rt];
    end

    always_comb begin
`ifdef PPCPU_FORWARD_EN
        stall = (ex_op == OP_LW) && (ex_dst != 5'd0) &&
                ((ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
`else
        stall = ((id_op != OP_NOP) && (id_rs != 5'd0) &&
                 ((ex_wr && ex_dst == id_rs) || (mem_wr && mem_dst == id_rs))) ||
                (id_uses_rt && (id_rt != 5'd0) &&
                 ((ex_wr && ex_dst == id_rt) || (mem_wr && mem_dst == id_rt)));
`endif
    end

    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        op_a = ex_a;
        op_b = ex_b;
`ifdef PPCPU_FORWARD_EN
        // EX/MEM wins over MEM/WB; load data is not yet available in EX/MEM
        if (mem_wr && !mem_load && mem_dst == ex_rs)
            op_a = MEM_ALU;
        else if (wb_wr && wb_dst == ex_rs)
            op_a = wb_val;
        if (mem_wr && !mem_load && mem_dst == ex_rt)
            op_b = MEM_ALU;
        else if (wb_wr && wb_dst == ex_rt)
            op_b = wb_val;
`endif
        case (ex_op)
            OP_ADD:                EXE_ALU = op_a + op_b;
            OP_SUB:                EXE_ALU = op_a - op_b;
            OP_AND:                EXE_ALU = op_a & op_b;
            OP_OR:                 EXE_ALU = op_a | op_b;
            OP_ADDI, OP_LW, OP_SW: EXE_ALU = op_a + ex_imm;
            OP_ANDI:               EXE_ALU = op_a & ex_imm;
            OP_ORI:                EXE_ALU = op_a | ex_imm;
            default:               EXE_ALU = '0;
        endcase
    end

    logic [31:0] mem_val;

    always_comb begin
        mem_val = mem_load ? ram[MEM_ALU[6:2]] : MEM_ALU;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            PC        <= '0;
            ID_INST   <= '0;
            ex_op     <= OP_NOP;
            ex_dst    <= '0;
            ex_wr     <= 1'b0;
            ex_imm    <= '0;
            ex_a      <= '0;
            ex_b      <= '0;
`ifdef PPCPU_FORWARD_EN
            ex_rs     <= '0;
            ex_rt     <= '0;
`endif
            MEM_ALU   <= '0;
            mem_sdata <= '0;
            mem_dst   <= '0;
            mem_wr    <= 1'b0;
            mem_load  <= 1'b0;
            mem_store <= 1'b0;
            WB_ALU    <= '0;
            wb_val    <= '0;
            wb_dst    <= '0;
            wb_wr     <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i[4:0]] <= '0;
                ram[i[4:0]]  <= (i == 32'd1) ? 32'h0000_000A : '0;
            end
        end else begin
            if (!stall) begin
                PC      <= PC + 32'd4;
                ID_INST <= IF_INST;
            end
            if (stall) begin
                ex_op  <= OP_NOP;
                ex_dst <= '0;
                ex_wr  <= 1'b0;
                ex_imm <= '0;
                ex_a   <= '0;
                ex_b   <= '0;
`ifdef PPCPU_FORWARD_EN
                ex_rs  <= '0;
                ex_rt  <= '0;
`endif
            end else begin
                ex_op  <= id_op;
                ex_dst <= id_dst;
                ex_wr  <= id_wr;
                ex_imm <= id_imm;
                ex_a   <= id_a;
                ex_b   <= id_b;
`ifdef PPCPU_FORWARD_EN
                ex_rs  <= id_rs;
                ex_rt  <= id_rt;
`endif
            end
            MEM_ALU   <= EXE_ALU;
            mem_sdata <= op_b;
            mem_dst   <= ex_dst;
            mem_wr    <= ex_wr;
            mem_load  <= (ex_op == OP_LW);
            mem_store <= (ex_op == OP_SW);
            WB_ALU    <= MEM_ALU;
            wb_val    <= mem_val;
            wb_dst    <= mem_dst;
            wb_wr     <= mem_wr;
            if (mem_store)
                ram[MEM_ALU[6:2]] <= mem_sdata;
            if (wb_wr)
                regs[wb_dst] <= wb_val;
        end
    end

endmodule

// File: tb/tb_ppcpu_forwarding_stall.sv
// Randomised-reset bench for ppcpu_forwarding_stall against an in-order ISA reference model.
// Honours PPCPU_FORWARD_EN to select the expected stall rule.
`timescale 1ns/1ps

module tb_ppcpu_forwarding_stall;

    logic        Clock  = 1'b0;
    logic        Resetn = 1'b0;
    logic [31:0] PC;
    logic [31:0] IF_INST;
    logic [31:0] ID_INST;
    logic [31:0] EXE_ALU;
    logic [31:0] MEM_ALU;
    logic [31:0] WB_ALU;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rom       [32];
    logic [31:0] res       [256];
    logic [31:0] arch_regs [32];

    // Instruction indices (program order) occupying each stage; -1 is empty/bubble
    int f;
    int id_k;
    int exe_k;
    int mem_k;
    int wb_k;

    ppcpu_forwarding_stall dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .PC      (PC),
        .IF_INST (IF_INST),
        .ID_INST (ID_INST),
        .EXE_ALU (EXE_ALU),
        .MEM_ALU (MEM_ALU),
        .WB_ALU  (WB_ALU),
        .stall   (stall)
    );

    always #5 Clock = ~Clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_r(input logic [31:0] w);
        return (w[31:26] == 6'h00) &&
               (w[5:0] == 6'h20 || w[5:0] == 6'h22 || w[5:0] == 6'h24 || w[5:0] == 6'h25);
    endfunction

    function automatic bit reads_rs(input logic [31:0] w);
        return is_r(w) || w[31:26] == 6'h08 || w[31:26] == 6'h0C || w[31:26] == 6'h0D ||
               w[31:26] == 6'h23 || w[31:26] == 6'h2B;
    endfunction

    function automatic bit reads_rt(input logic [31:0] w);
        return is_r(w) || w[31:26] == 6'h2B;
    endfunction

    function automatic logic [4:0] dest_of(input logic [31:0] w);
        if (is_r(w))
            return w[15:11];
        if (w[31:26] == 6'h08 || w[31:26] == 6'h0C || w[31:26] == 6'h0D || w[31:26] == 6'h23)
            return w[20:16];
        return 5'd0;
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] se;
        logic [31:0] ze;
        se = {{16{w[15]}}, w[15:0]};
        ze = {16'h0000, w[15:0]};
        if (is_r(w)) begin
            case (w[5:0])
                6'h20:   return a + b;
                6'h22:   return a - b;
                6'h24:   return a & b;
                default: return a | b;
            endcase
        end
        case (w[31:26])
            6'h08, 6'h23, 6'h2B: return a + se;
            6'h0C:               return a & ze;
            6'h0D:               return a | ze;
            default:             return 32'h0;
        endcase
    endfunction

    // Sequential ISA execution: per-instruction ALU results and the state after the program body
    task automatic run_iss();
        logic [31:0] r [32];
        logic [31:0] m [32];
        logic [31:0] w;
        logic [31:0] v;
        logic [4:0]  d;
        for (int i = 0; i < 32; i++) begin
            r[i] = '0;
            m[i] = (i == 1) ? 32'h0000_000A : 32'h0;
        end
        for (int k = 0; k < 256; k++) begin
            w = rom[k % 32];
            v = alu(w, r[w[25:21]], r[w[20:16]]);
            res[k] = v;
            d = dest_of(w);
            if (w[31:26] == 6'h2B)
                m[v[6:2]] = r[w[20:16]];
            else if (d != 5'd0)
                r[d] = (w[31:26] == 6'h23) ? m[v[6:2]] : v;
            if (k == 7)
                for (int i = 0; i < 32; i++) arch_regs[i] = r[i];
        end
    endtask

    function automatic bit hazard(input int idk, input int exk, input int mmk);
        logic [31:0] w;
        logic [31:0] e;
`ifndef PPCPU_FORWARD_EN
        logic [4:0]  d;
        int          k;
`endif
        if (idk < 0)
            return 1'b0;
        w = rom[idk % 32];
`ifdef PPCPU_FORWARD_EN
        if (exk < 0)
            return 1'b0;
        e = rom[exk % 32];
        if (e[31:26] != 6'h23 || e[20:16] == 5'd0)
            return 1'b0;
        return (e[20:16] == w[25:21]) || (reads_rt(w) && e[20:16] == w[20:16]);
`else
        for (int p = 0; p < 2; p++) begin
            k = (p == 0) ? exk : mmk;
            if (k >= 0) begin
                e = rom[k % 32];
                d = dest_of(e);
                if (d != 5'd0 && ((reads_rs(w) && w[25:21] == d) || (reads_rt(w) && w[20:16] == d)))
                    return 1'b1;
            end
        end
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] res_of(input int k);
        return (k < 0) ? 32'h0 : res[k];
    endfunction

    task automatic model_reset();
        f     = 0;
        id_k  = -1;
        exe_k = -1;
        mem_k = -1;
        wb_k  = -1;
    endtask

    task automatic model_edge();
        bit s;
        s     = hazard(id_k, exe_k, mem_k);
        wb_k  = mem_k;
        mem_k = exe_k;
        exe_k = s ? -1 : id_k;
        if (!s) begin
            id_k = f;
            f++;
        end
    endtask

    task automatic check_all();
        check_eq("PC",      PC,             32'(4 * f));
        check_eq("IF_INST", IF_INST,        rom[f % 32]);
        check_eq("ID_INST", ID_INST,        (id_k < 0) ? 32'h0 : rom[id_k % 32]);
        check_eq("EXE_ALU", EXE_ALU,        res_of(exe_k));
        check_eq("MEM_ALU", MEM_ALU,        res_of(mem_k));
        check_eq("WB_ALU",  WB_ALU,         res_of(wb_k));
        check_eq("stall",   {31'b0, stall}, {31'b0, hazard(id_k, exe_k, mem_k)});
    endtask

    task automatic run_cycles(input int n);
        repeat (n) begin
            @(posedge Clock);
            model_edge();
            @(negedge Clock);
            check_all();
        end
    endtask

    task automatic pulse_reset();
        @(posedge Clock);
        #($urandom_range(1, 3));
        Resetn = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat ($urandom_range(1, 3)) begin
            @(negedge Clock);
            check_all();
        end
        @(negedge Clock);
        #2 Resetn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'h0;
        rom[0] = 32'h2001_0004;
        rom[1] = 32'h8C22_0000;
        rom[2] = 32'h0041_1820;
        rom[3] = 32'h0061_2022;
        rom[4] = 32'hAC04_0008;
        rom[5] = 32'h8C05_0008;
        rom[6] = 32'h00A3_3025;
        rom[7] = 32'h00C4_3824;
        run_iss();
        model_reset();

        #1 check_all();
        repeat (2) begin
            @(negedge Clock);
            check_all();
        end
        #2 Resetn = 1'b1;

        // Long enough for the PC to pass 128 bytes and refetch ROM word 0
        run_cycles(80);

        for (int seg = 0; seg < 6; seg++) begin
            pulse_reset();
            run_cycles($urandom_range(5, 90));
        end

        pulse_reset();
        run_cycles(45);
        for (int i = 1; i < 8; i++)
            check_eq($sformatf("r%0d", i), dut.regs[i], arch_regs[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
